hawk_att_lkup_rd: RTL and testbench

- Stage between the HACD lookup request path and the Hawk page-read manager.
- Accepts one ATT lookup request and issues a single-beat AXI4 read for the 64B ATT cacheline holding the entry.
- Decodes the 64-bit entry selected by hppa[14:12] into a trnsl_reqpkt_t, including the zero-page-detect count update, and hands it downstream with valid/ready.
- One lookup in flight; no reordering.

---
 rtl/hacd_pkg.sv | 59 +++++
 rtl/hawk_rd_pkg.sv | 49 ++++
 rtl/hawk_att_line_cache.sv | 44 ++++
 rtl/hawk_att_lkup_rd.sv | 168 ++++++++++++++++
 tb/tb_hawk_att_lkup_rd.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hacd_pkg.sv
// HACD shared types and constants used by the Hawk read path: AXI4 widths,
// host page range, ATT entry layout and request/translation packets.
package hacd_pkg;

   localparam int unsigned HACD_AXI4_ADDR_WIDTH = 64;
   localparam int unsigned HACD_AXI4_DATA_WIDTH = 512;
   localparam int unsigned HACD_AXI4_ID_WIDTH   = 4;

   localparam logic [HACD_AXI4_ADDR_WIDTH-1:0] HPPA_BASE_ADDR = 64'h0000_0001_0000_0000;
   localparam logic [HACD_AXI4_ADDR_WIDTH-1:0] HAWK_ATT_START = 64'h0000_0000_8000_0000;
   localparam int unsigned ATT_ENTRY_MAX = 1024;

   // Bits needed to hold 'value' itself (1-based ids reach ATT_ENTRY_MAX).
   function automatic int unsigned clogb2(input int unsigned value);
      int unsigned v;
      int unsigned n;
      v = value;
      n = 0;
      while (v > 0) begin
         n++;
         v = v >> 1;
      end
      return n;
   endfunction

   typedef enum logic [1:0] {
      AXI_OKAY   = 2'b00,
      AXI_EXOKAY = 2'b01,
      AXI_SLVERR = 2'b10,
      AXI_DECERR = 2'b11
   } axi_resp_t;

   typedef enum logic [3:0] {
      STS_DEALLOC = 4'd0,
      INCOMP      = 4'd1,
      COMPRESSED  = 4'd2,
      PENDING     = 4'd3
   } att_sts_t;

   typedef struct packed {
      logic [7:0]  zpd_cnt;
      att_sts_t    sts;
      logic [51:0] way;
   } AttEntry;

   typedef struct packed {
      logic [HACD_AXI4_ADDR_WIDTH-1:0] hppa;
      logic                            zeroBlkWr;
   } att_lkup_reqpkt_t;

   typedef struct packed {
      logic [7:0]                      zpd_cnt;
      logic                            zpd_update;
      logic [HACD_AXI4_ADDR_WIDTH-1:0] ppa;
      att_sts_t                        sts;
      logic                            allow_access;
   } trnsl_reqpkt_t;

endpackage

// File: rtl/hawk_rd_pkg.sv
// Hawk read-path helpers: ATT lookup FSM states, ATT line addressing and
// ATT entry decode with zero-page-detect count update.
package hawk_rd_pkg;
   import hacd_pkg::*;

   localparam int unsigned ATT_ID_W = clogb2(ATT_ENTRY_MAX);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE_AR,
      WAIT_R,
      RESP
   } att_lkup_state_t;

   // Eight 64-bit entries per 64B line; ids are 1-based.
   function automatic logic [HACD_AXI4_ADDR_WIDTH-1:0] get_att_line_addr(
      input logic [ATT_ID_W-1:0] att_entry_id
   );
      logic [HACD_AXI4_ADDR_WIDTH-1:0] idx;
      idx = HACD_AXI4_ADDR_WIDTH'(att_entry_id) - HACD_AXI4_ADDR_WIDTH'(1);
      return HAWK_ATT_START + ((idx >> 3) << 6);
   endfunction

   function automatic trnsl_reqpkt_t decode_att_entry(
      input att_lkup_reqpkt_t                reqpkt,
      input logic [HACD_AXI4_DATA_WIDTH-1:0] rdata
   );
      AttEntry       entry;
      trnsl_reqpkt_t pkt;
      entry = AttEntry'(rdata[{reqpkt.hppa[14:12], 6'b000} +: 64]);
      pkt   = '0;
      // Count wraps at 255; compression is triggered well before that.
      if (reqpkt.zeroBlkWr) begin
         pkt.zpd_cnt    = entry.zpd_cnt + 8'd1;
         pkt.zpd_update = 1'b1;
      end else if (entry.zpd_cnt != '0) begin
         pkt.zpd_cnt    = '0;
         pkt.zpd_update = 1'b1;
      end else begin
         pkt.zpd_cnt    = entry.zpd_cnt;
         pkt.zpd_update = 1'b0;
      end
      pkt.ppa          = {entry.way, 12'h000};
      pkt.sts          = entry.sts;
      pkt.allow_access = (entry.sts == INCOMP);
      return pkt;
   endfunction

endpackage

// File: rtl/hawk_att_line_cache.sv
// Single-line ATT cache (tag, 512-bit line, valid); only built when
// HAWK_ATT_LINE_CACHE_EN is defined. Invalidate beats a coincident refill.
`ifdef HAWK_ATT_LINE_CACHE_EN
module hawk_att_line_cache
   import hacd_pkg::*;
(
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic [HACD_AXI4_ADDR_WIDTH-1:0] lookup_addr,
   output logic                            hit,
   output logic [HACD_AXI4_DATA_WIDTH-1:0] line_data,
   input  logic                            refill_en,
   input  logic [HACD_AXI4_ADDR_WIDTH-1:0] refill_addr,
   input  logic [HACD_AXI4_DATA_WIDTH-1:0] refill_data,
   input  logic                            inv
);

   logic                            valid_q;
   logic [HACD_AXI4_ADDR_WIDTH-1:0] tag_q;
   logic [HACD_AXI4_DATA_WIDTH-1:0] data_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         tag_q   <= '0;
         data_q  <= '0;
      end else begin
         if (inv) begin
            valid_q <= 1'b0;
         end else if (refill_en) begin
            valid_q <= 1'b1;
         end
         if (refill_en) begin
            tag_q  <= refill_addr;
            data_q <= refill_data;
         end
      end
   end

   assign hit       = valid_q && !inv && (tag_q == lookup_addr);
   assign line_data = data_q;

endmodule
`endif

// File: rtl/hawk_att_lkup_rd.sv
// ATT lookup stage: one request -> single-beat AXI4 read of the ATT line ->
// decoded translation packet. Optional line cache: HAWK_ATT_LINE_CACHE_EN.
module hawk_att_lkup_rd
   import hacd_pkg::*;
   import hawk_rd_pkg::*;
#(
   parameter logic [HACD_AXI4_ID_WIDTH-1:0]   AXI_ID    = '0,
   parameter logic [HACD_AXI4_ADDR_WIDTH-1:0] HPPA_BASE = HPPA_BASE_ADDR
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic                            lkup_req_vld,
   input  att_lkup_reqpkt_t                lkup_reqpkt,
   output logic                            lkup_req_rdy,
   output logic                            m_arvalid,
   input  logic                            m_arready,
   output logic [HACD_AXI4_ADDR_WIDTH-1:0] m_araddr,
   output logic [7:0]                      m_arlen,
   output logic [HACD_AXI4_ID_WIDTH-1:0]   m_arid,
   input  logic                            m_rvalid,
   output logic                            m_rready,
   input  logic [HACD_AXI4_DATA_WIDTH-1:0] m_rdata,
   input  logic [1:0]                      m_rresp,
   input  logic                            m_rlast,
`ifdef HAWK_ATT_LINE_CACHE_EN
   input  logic                            att_line_inv,
`endif
   output logic                            trnsl_vld,
   output trnsl_reqpkt_t                   trnsl_pkt,
   input  logic                            trnsl_rdy,
   output logic                            lkup_err
);

   localparam int unsigned PAGE_W = HACD_AXI4_ADDR_WIDTH - 12;

   att_lkup_state_t                 state_q, state_d;
   att_lkup_reqpkt_t                req_q, req_d;
   logic [HACD_AXI4_ADDR_WIDTH-1:0] araddr_q, araddr_d;
   trnsl_reqpkt_t                   pkt_q, pkt_d;
   logic                            err_q, err_d;
   logic                            beat_seen_q, beat_seen_d;
   logic                            first_ok_q, first_ok_d;

   logic [PAGE_W-1:0]               page_off;
   logic                            in_range;
   logic [ATT_ID_W-1:0]             entry_id;
   logic [HACD_AXI4_ADDR_WIDTH-1:0] req_line_addr;
   logic                            beat_ok;
   logic                            refill_en;
   logic                            cache_hit;
   logic [HACD_AXI4_DATA_WIDTH-1:0] cache_line;

   // HPPA_BASE is 32KB aligned, so the page offset is exact on hppa[63:12].
   assign page_off      = lkup_reqpkt.hppa[HACD_AXI4_ADDR_WIDTH-1:12] - HPPA_BASE[HACD_AXI4_ADDR_WIDTH-1:12];
   assign in_range      = (lkup_reqpkt.hppa >= HPPA_BASE) && (page_off < PAGE_W'(ATT_ENTRY_MAX));
   assign entry_id      = page_off[ATT_ID_W-1:0] + ATT_ID_W'(1);
   assign req_line_addr = get_att_line_addr(entry_id);

   // Only the first R beat counts; trailing beats of a burst are drained.
   assign beat_ok   = beat_seen_q ? first_ok_q : (m_rresp == AXI_OKAY);
   assign refill_en = (state_q == WAIT_R) && m_rvalid && !beat_seen_q && (m_rresp == AXI_OKAY);

`ifdef HAWK_ATT_LINE_CACHE_EN
   hawk_att_line_cache u_line_cache (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .lookup_addr (req_line_addr),
      .hit         (cache_hit),
      .line_data   (cache_line),
      .refill_en   (refill_en),
      .refill_addr (araddr_q),
      .refill_data (m_rdata),
      .inv         (att_line_inv)
   );
`else
   assign cache_hit  = 1'b0;
   assign cache_line = '0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         req_q       <= '0;
         araddr_q    <= '0;
         pkt_q       <= '0;
         err_q       <= 1'b0;
         beat_seen_q <= 1'b0;
         first_ok_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         araddr_q    <= araddr_d;
         pkt_q       <= pkt_d;
         err_q       <= err_d;
         beat_seen_q <= beat_seen_d;
         first_ok_q  <= first_ok_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      req_d        = req_q;
      araddr_d     = araddr_q;
      pkt_d        = pkt_q;
      err_d        = 1'b0;
      beat_seen_d  = beat_seen_q;
      first_ok_d   = first_ok_q;
      lkup_req_rdy = 1'b0;
      m_arvalid    = 1'b0;
      m_rready     = 1'b0;
      trnsl_vld    = 1'b0;
      unique case (state_q)
         IDLE: begin
            lkup_req_rdy = !rst_i;
            if (lkup_req_vld && !rst_i) begin
               req_d = lkup_reqpkt;
               if (!in_range) begin
                  err_d = 1'b1;
               end else begin
                  araddr_d = req_line_addr;
                  if (cache_hit) begin
                     pkt_d   = decode_att_entry(lkup_reqpkt, cache_line);
                     state_d = RESP;
                  end else begin
                     state_d = ISSUE_AR;
                  end
               end
            end
         end
         ISSUE_AR: begin
            m_arvalid = !rst_i;
            if (m_arready) state_d = WAIT_R;
         end
         WAIT_R: begin
            m_rready = !rst_i;
            if (m_rvalid) begin
               if (!beat_seen_q) begin
                  pkt_d      = decode_att_entry(req_q, m_rdata);
                  first_ok_d = (m_rresp == AXI_OKAY);
               end
               if (m_rlast) begin
                  beat_seen_d = 1'b0;
                  if (beat_ok) begin
                     state_d = RESP;
                  end else begin
                     err_d   = 1'b1;
                     state_d = IDLE;
                  end
               end else begin
                  beat_seen_d = 1'b1;
               end
            end
         end
         RESP: begin
            trnsl_vld = !rst_i;
            if (trnsl_rdy) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign m_araddr  = araddr_q;
   assign m_arlen   = '0;
   assign m_arid    = AXI_ID;
   assign trnsl_pkt = pkt_q;
   assign lkup_err  = err_q;

endmodule

// File: tb/tb_hawk_att_lkup_rd.sv
// Directed self-checking bench for hawk_att_lkup_rd; the line-cache scenario
// is compiled in with HAWK_ATT_LINE_CACHE_EN.
`timescale 1ns/1ps
module tb_hawk_att_lkup_rd;
   import hacd_pkg::*;
   import hawk_rd_pkg::*;

   localparam logic [63:0] BASE = 64'h0000_0001_0000_0000;
   localparam logic [63:0] ATT0 = 64'h0000_0000_8000_0000;

   logic             clk = 1'b0;
   logic             rst_i;
   logic             lkup_req_vld;
   att_lkup_reqpkt_t lkup_reqpkt;
   logic             lkup_req_rdy;
   logic             m_arvalid;
   logic             m_arready;
   logic [63:0]      m_araddr;
   logic [7:0]       m_arlen;
   logic [3:0]       m_arid;
   logic             m_rvalid;
   logic             m_rready;
   logic [511:0]     m_rdata;
   logic [1:0]       m_rresp;
   logic             m_rlast;
`ifdef HAWK_ATT_LINE_CACHE_EN
   logic             att_line_inv;
`endif
   logic             trnsl_vld;
   trnsl_reqpkt_t    trnsl_pkt;
   logic             trnsl_rdy;
   logic             lkup_err;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   hawk_att_lkup_rd #(.AXI_ID(4'h3), .HPPA_BASE(BASE)) dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .lkup_req_vld (lkup_req_vld),
      .lkup_reqpkt  (lkup_reqpkt),
      .lkup_req_rdy (lkup_req_rdy),
      .m_arvalid    (m_arvalid),
      .m_arready    (m_arready),
      .m_araddr     (m_araddr),
      .m_arlen      (m_arlen),
      .m_arid       (m_arid),
      .m_rvalid     (m_rvalid),
      .m_rready     (m_rready),
      .m_rdata      (m_rdata),
      .m_rresp      (m_rresp),
      .m_rlast      (m_rlast),
`ifdef HAWK_ATT_LINE_CACHE_EN
      .att_line_inv (att_line_inv),
`endif
      .trnsl_vld    (trnsl_vld),
      .trnsl_pkt    (trnsl_pkt),
      .trnsl_rdy    (trnsl_rdy),
      .lkup_err     (lkup_err)
   );

   // ---------------- stimulus construction ----------------
   function automatic logic [63:0] ent(input logic [7:0] cnt, input logic [51:0] way, input att_sts_t sts);
      return {cnt, sts, way};
   endfunction

   // Filler entries differ per slot so a wrong slot select shows up.
   function automatic logic [511:0] line_with(input int unsigned idx, input logic [63:0] e);
      logic [511:0] l;
      for (int unsigned k = 0; k < 8; k++) l[64*k +: 64] = ent(8'hA0 + 8'(k), 52'h0F00 + 52'(k), PENDING);
      l[64*idx +: 64] = e;
      return l;
   endfunction

   function automatic trnsl_reqpkt_t mk_pkt(input logic [7:0] cnt, input logic upd, input logic [63:0] ppa,
                                            input att_sts_t sts, input logic allow);
      trnsl_reqpkt_t p;
      p.zpd_cnt = cnt; p.zpd_update = upd; p.ppa = ppa; p.sts = sts; p.allow_access = allow;
      return p;
   endfunction

   // ---------------- stimulus tasks (all at negedge) ----------------
   task automatic start_test();
      @(negedge clk);
`ifdef HAWK_ATT_LINE_CACHE_EN
      att_line_inv = 1'b1;
      @(negedge clk);
      att_line_inv = 1'b0;
`endif
   endtask

   task automatic send_req(input logic [63:0] hppa, input logic zbw, output logic rdy_seen, output logic err_seen);
      lkup_req_vld          = 1'b1;
      lkup_reqpkt.hppa      = hppa;
      lkup_reqpkt.zeroBlkWr = zbw;
      rdy_seen              = lkup_req_rdy;
      @(negedge clk);
      lkup_req_vld = 1'b0;
      err_seen     = lkup_err;
   endtask

   task automatic wait_ar(output int unsigned waited, output logic [63:0] addr);
      waited = 0;
      while (!m_arvalid && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      addr = m_araddr;
      if (m_arvalid) begin
         m_arready = 1'b1;
         @(negedge clk);
         m_arready = 1'b0;
      end
   endtask

   task automatic serve_r(input logic [511:0] l0, input logic [511:0] l1, input logic [1:0] resp, input int unsigned nbeats);
      for (int unsigned b = 0; b < nbeats; b++) begin
         m_rvalid = 1'b1;
         m_rdata  = (b == 0) ? l0 : l1;
         m_rresp  = resp;
         m_rlast  = (b == nbeats - 1);
         @(negedge clk);
      end
      m_rvalid = 1'b0; m_rlast = 1'b0; m_rdata = '0; m_rresp = 2'b00;
   endtask

   task automatic wait_trnsl(output int unsigned waited, output trnsl_reqpkt_t pkt);
      waited = 0;
      while (!trnsl_vld && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      pkt = trnsl_pkt;
   endtask

   task automatic take_trnsl();
      trnsl_rdy = 1'b1;
      @(negedge clk);
      trnsl_rdy = 1'b0;
   endtask

   // Full miss-path lookup with inline checks of address, latency and packet.
   task automatic lookup_check(input string name, input logic [63:0] hppa, input logic zbw,
                               input logic [511:0] line, input logic [63:0] exp_addr, input trnsl_reqpkt_t exp_pkt);
      logic rdy, err; int unsigned w; logic [63:0] addr; trnsl_reqpkt_t pkt;
      start_test();
      send_req(hppa, zbw, rdy, err);
      tests_run++;
      if ({rdy, err} !== 2'b10) begin
         tests_failed++; $display("FAIL %s accept: rdy/err got %b required 10", name, {rdy, err});
      end
      wait_ar(w, addr);
      tests_run++;
      if (w !== 0 || addr !== exp_addr) begin
         tests_failed++; $display("FAIL %s araddr: got %h after %0d cycles, required %h after 0", name, addr, w, exp_addr);
      end
      serve_r(line, '0, 2'b00, 1);
      wait_trnsl(w, pkt);
      tests_run++;
      if (w !== 0 || pkt !== exp_pkt) begin
         tests_failed++; $display("FAIL %s trnsl_pkt: got %h after %0d cycles, required %h after 0", name, pkt, w, exp_pkt);
      end
      take_trnsl();
      tests_run++;
      if (lkup_req_rdy !== 1'b1 || trnsl_vld !== 1'b0) begin
         tests_failed++; $display("FAIL %s return_idle: rdy/vld got %b%b required 10", name, lkup_req_rdy, trnsl_vld);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_i = 1'b1; lkup_req_vld = 1'b0; lkup_reqpkt = '0; m_arready = 1'b0; m_rvalid = 1'b0;
      m_rdata = '0; m_rresp = 2'b00; m_rlast = 1'b0; trnsl_rdy = 1'b0;
`ifdef HAWK_ATT_LINE_CACHE_EN
      att_line_inv = 1'b0;
`endif
      repeat (3) @(negedge clk);
      tests_run++;
      if ({lkup_req_rdy, m_arvalid, m_rready, trnsl_vld, lkup_err} !== 5'b0) begin
         tests_failed++;
         $display("FAIL reset_ctrl: rdy,arv,rrdy,vld,err got %b required 00000",
                  {lkup_req_rdy, m_arvalid, m_rready, trnsl_vld, lkup_err});
      end
      tests_run++;
      if (m_araddr !== 64'h0 || m_arlen !== 8'h0 || trnsl_pkt !== '0) begin
         tests_failed++; $display("FAIL reset_data: araddr %h arlen %h pkt %h, required all zero", m_araddr, m_arlen, trnsl_pkt);
      end
      rst_i = 1'b0;
      @(negedge clk);
      tests_run++;
      if (lkup_req_rdy !== 1'b1 || m_arid !== 4'h3) begin
         tests_failed++; $display("FAIL idle_after_reset: rdy %b arid %h, required 1 and 3", lkup_req_rdy, m_arid);
      end
   endtask

   task automatic test_out_of_range();
      logic rdy, err;
      logic [63:0] bad [2];
      bad[0] = BASE - 64'h1000;
      bad[1] = BASE + 64'h40_0000;
      for (int i = 0; i < 2; i++) begin
         start_test();
         send_req(bad[i], 1'b0, rdy, err);
         tests_run++;
         if ({rdy, err, m_arvalid} !== 3'b110) begin
            tests_failed++; $display("FAIL range_err[%0d]: rdy,err,arvalid got %b required 110", i, {rdy, err, m_arvalid});
         end
         @(negedge clk);
         tests_run++;
         if ({lkup_req_rdy, lkup_err, m_arvalid} !== 3'b100) begin
            tests_failed++; $display("FAIL range_pulse[%0d]: rdy,err,arvalid got %b required 100", i, {lkup_req_rdy, lkup_err, m_arvalid});
         end
      end
   endtask

   task automatic test_slverr();
      logic rdy, err; int unsigned w; logic [63:0] addr;
      start_test();
      send_req(BASE + 64'h1000, 1'b0, rdy, err);
      wait_ar(w, addr);
      serve_r(line_with(1, ent(8'd0, 52'h42, INCOMP)), '0, 2'b10, 1);
      tests_run++;
      if ({lkup_err, trnsl_vld} !== 2'b10) begin
         tests_failed++; $display("FAIL slverr_err: err,vld got %b required 10", {lkup_err, trnsl_vld});
      end
      @(negedge clk);
      tests_run++;
      if ({lkup_err, trnsl_vld, lkup_req_rdy} !== 3'b001) begin
         tests_failed++; $display("FAIL slverr_idle: err,vld,rdy got %b required 001", {lkup_err, trnsl_vld, lkup_req_rdy});
      end
   endtask

   task automatic test_multi_beat();
      logic rdy, err; int unsigned w; logic [63:0] addr; trnsl_reqpkt_t pkt;
      start_test();
      send_req(BASE + 64'h2000, 1'b0, rdy, err);
      wait_ar(w, addr);
      serve_r(line_with(2, ent(8'd3, 52'h99, INCOMP)), line_with(2, ent(8'd0, 52'h11, COMPRESSED)), 2'b00, 3);
      wait_trnsl(w, pkt);
      tests_run++;
      if (w !== 0 || pkt !== mk_pkt(8'd0, 1'b1, 64'h99000, INCOMP, 1'b1)) begin
         tests_failed++; $display("FAIL multi_beat: got %h after %0d cycles, required first-beat entry", pkt, w);
      end
      take_trnsl();
   endtask

   task automatic test_back_pressure();
      logic rdy, err; int unsigned w; logic [63:0] addr; trnsl_reqpkt_t pkt, exp;
      exp = mk_pkt(8'd0, 1'b0, 64'h321000, COMPRESSED, 1'b0);
      start_test();
      send_req(BASE + 64'h4000, 1'b0, rdy, err);
      wait_ar(w, addr);
      serve_r(line_with(4, ent(8'd0, 52'h321, COMPRESSED)), '0, 2'b00, 1);
      wait_trnsl(w, pkt);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         tests_run++;
         if (trnsl_vld !== 1'b1 || trnsl_pkt !== exp || lkup_req_rdy !== 1'b0) begin
            tests_failed++;
            $display("FAIL back_pressure[%0d]: vld %b rdy %b pkt %h, required 1 0 %h", i, trnsl_vld, lkup_req_rdy, trnsl_pkt, exp);
         end
      end
      take_trnsl();
   endtask

   task automatic test_reset_mid();
      logic rdy, err; int unsigned w;
      start_test();
      send_req(BASE + 64'h3000, 1'b0, rdy, err);
      w = 0;
      while (!m_arvalid && w < 20) begin
         @(negedge clk);
         w++;
      end
      rst_i = 1'b1;
      #1;
      tests_run++;
      if (m_arvalid !== 1'b0) begin
         tests_failed++; $display("FAIL reset_mid_arvalid: got %b required 0", m_arvalid);
      end
      @(negedge clk);
      rst_i = 1'b0;
      @(negedge clk);
      tests_run++;
      if ({lkup_req_rdy, m_arvalid, m_rready} !== 3'b100) begin
         tests_failed++; $display("FAIL reset_mid_idle: rdy,arv,rrdy got %b required 100", {lkup_req_rdy, m_arvalid, m_rready});
      end
   endtask

`ifdef HAWK_ATT_LINE_CACHE_EN
   task automatic test_line_cache();
      logic rdy, err; int unsigned w; logic [63:0] addr; trnsl_reqpkt_t pkt;
      logic [511:0] l;
      l = line_with(3, ent(8'd0, 52'h42, INCOMP));
      l[64*5 +: 64] = ent(8'd9, 52'h777, COMPRESSED);
      start_test();
      send_req(BASE + 64'h3000, 1'b0, rdy, err);
      wait_ar(w, addr);
      serve_r(l, '0, 2'b00, 1);
      wait_trnsl(w, pkt);
      take_trnsl();
      send_req(BASE + 64'h5000, 1'b1, rdy, err);
      tests_run++;
      if (m_arvalid !== 1'b0 || trnsl_vld !== 1'b1 || trnsl_pkt !== mk_pkt(8'd10, 1'b1, 64'h777000, COMPRESSED, 1'b0)) begin
         tests_failed++; $display("FAIL cache_hit: arv %b vld %b pkt %h, required 0 1 cached entry5", m_arvalid, trnsl_vld, trnsl_pkt);
      end
      take_trnsl();
      att_line_inv = 1'b1;
      @(negedge clk);
      att_line_inv = 1'b0;
      send_req(BASE + 64'h5000, 1'b1, rdy, err);
      wait_ar(w, addr);
      tests_run++;
      if (w !== 0 || addr !== ATT0) begin
         tests_failed++; $display("FAIL cache_inv_miss: araddr %h after %0d cycles, required %h after 0", addr, w, ATT0);
      end
      serve_r(l, '0, 2'b00, 1);
      wait_trnsl(w, pkt);
      take_trnsl();
   endtask
`endif

   initial begin
      test_reset();
      lookup_check("basic_incomp", BASE + 64'h3000, 1'b0, line_with(3, ent(8'd0, 52'h42, INCOMP)),
                   ATT0, mk_pkt(8'd0, 1'b0, 64'h42000, INCOMP, 1'b1));
      lookup_check("zero_blk_wr", BASE + 64'h9000, 1'b1, line_with(1, ent(8'd5, 52'h7, COMPRESSED)),
                   ATT0 + 64'h40, mk_pkt(8'd6, 1'b1, 64'h7000, COMPRESSED, 1'b0));
      lookup_check("zpd_clear", BASE + 64'h5000, 1'b0, line_with(5, ent(8'd7, 52'h123, INCOMP)),
                   ATT0, mk_pkt(8'd0, 1'b1, 64'h123000, INCOMP, 1'b1));
      lookup_check("zpd_wrap", BASE + 64'h7000, 1'b1, line_with(7, ent(8'd255, 52'hABCDE, COMPRESSED)),
                   ATT0, mk_pkt(8'd0, 1'b1, 64'hABCDE000, COMPRESSED, 1'b0));
      lookup_check("last_entry", BASE + 64'h3F_F000, 1'b0, line_with(7, ent(8'd0, 52'h55, INCOMP)),
                   ATT0 + 64'h1FC0, mk_pkt(8'd0, 1'b0, 64'h55000, INCOMP, 1'b1));
      test_out_of_range();
      test_slverr();
      test_multi_beat();
      test_back_pressure();
      test_reset_mid();
`ifdef HAWK_ATT_LINE_CACHE_EN
      test_line_cache();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within 200us");
      $fatal(1);
   end

endmodule
